// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and widths for the pipeline hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;
    localparam int FLUSH_CNT_W = 3;
    localparam int REG_IDX_W = 5;
endpackage

// File: rtl/hazard_load_use_detect.sv
// hazard_load_use_detect: flags an ID-stage read of a register still being loaded in EX
module hazard_load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 load_use_o
);
    assign load_use_o = ex_mem_read_i && ex_rd_i != '0 &&
                        ((id_use_rs1_i && id_rs1_i == ex_rd_i) ||
                         (id_use_rs2_i && id_rs2_i == ex_rd_i));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer (freeze > mispredict flush > load-use bubble)
// Optional HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_br_valid_i,
    input  logic                 ex_br_taken_i,
    input  logic                 ex_br_pred_i,
    input  logic                 dmem_busy_i,
    output logic                 pc_stall_o,
    output logic                 if_id_stall_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_stall_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_stall_o,
    output logic                 pc_redirect_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          flush_cnt_o
`endif
);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 state, state_n;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_n;
    logic                   mis_pend, mis_pend_n;
    logic                   load_use, mispredict, freeze, do_mis, do_flush, do_lu;

    hazard_load_use_detect u_lu (
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .ex_rd_i      (ex_rd_i),
        .ex_mem_read_i(ex_mem_read_i),
        .load_use_o   (load_use)
    );

    // A freeze entered from FLUSH keeps a non-zero cnt, which is how it knows to resume flushing
    always_comb begin
        mispredict = ex_br_valid_i && (ex_br_taken_i != ex_br_pred_i);
        freeze     = dmem_busy_i;
        do_mis     = !freeze && (state == RUN ? mispredict : (state == FREEZE && mis_pend));
        do_flush   = !freeze && (state == FLUSH || (state == FREEZE && cnt != '0));
        do_lu      = !freeze && !do_mis && !do_flush && load_use;
        state_n    = freeze   ? FREEZE :
                     do_mis   ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
                     do_flush ? (cnt == FLUSH_CNT_W'(1) ? RUN : FLUSH) : RUN;
        cnt_n      = freeze ? cnt : do_mis ? FLUSH_INIT : do_flush ? cnt - 1'b1 : '0;
        mis_pend_n = freeze && (mis_pend || (mispredict && cnt == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            mis_pend <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mis_pend <= mis_pend_n;
        end
    end

    assign pc_stall_o     = !reset && (freeze || do_lu);
    assign if_id_stall_o  = !reset && (freeze || do_lu);
    assign id_ex_stall_o  = !reset && freeze;
    assign ex_mem_stall_o = !reset && freeze;
    assign if_id_flush_o  = !reset && (do_mis || do_flush);
    assign id_ex_flush_o  = !reset && (do_mis || do_flush || do_lu);
    assign pc_redirect_o  = !reset && do_mis;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            stall_cnt_o <= stall_cnt_o + 32'(pc_stall_o);
            flush_cnt_o <= flush_cnt_o + 32'(pc_redirect_o);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: vector table plus multi-cycle sequences against FLUSH_CYCLES=2 and =3 instances
module tb_hazard_controller;
    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, bv, bt, bp, busy;
    } in_t;
    typedef struct {
        in_t        i;
        logic [6:0] e2, e3;
    } vec_t;
    typedef struct packed {
        logic [6:0] e2, e3;
        logic       r;
    } sb_t;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect}
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] LU  = 7'b1100100;
    localparam logic [6:0] FRZ = 7'b1101010;
    localparam logic [6:0] MIS = 7'b0010101;
    localparam logic [6:0] FL  = 7'b0010100;

    logic       clk = 1'b0, reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
    logic       br_valid = 0, br_taken = 0, br_pred = 0, dmem_busy = 0;
    wire  [6:0] o2, o3;
    int         total = 0, bad = 0;
    sb_t        q[$];
    vec_t       tbl[13];
    logic [31:0] m_s2 = 0, m_f2 = 0, m_s3 = 0, m_f3 = 0;
`ifdef HAZARD_PERF_CNT_EN
    wire [31:0] sc2, fc2, sc3, fc3;
`endif

    always #5 clk = ~clk;

    hazard_controller #(.FLUSH_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .ex_rd_i(ex_rd),
        .ex_mem_read_i(ex_mem_read), .ex_br_valid_i(br_valid), .ex_br_taken_i(br_taken),
        .ex_br_pred_i(br_pred), .dmem_busy_i(dmem_busy),
        .pc_stall_o(o2[6]), .if_id_stall_o(o2[5]), .if_id_flush_o(o2[4]),
        .id_ex_stall_o(o2[3]), .id_ex_flush_o(o2[2]), .ex_mem_stall_o(o2[1]),
        .pc_redirect_o(o2[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(sc2), .flush_cnt_o(fc2)
`endif
    );

    hazard_controller #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .ex_rd_i(ex_rd),
        .ex_mem_read_i(ex_mem_read), .ex_br_valid_i(br_valid), .ex_br_taken_i(br_taken),
        .ex_br_pred_i(br_pred), .dmem_busy_i(dmem_busy),
        .pc_stall_o(o3[6]), .if_id_stall_o(o3[5]), .if_id_flush_o(o3[4]),
        .id_ex_stall_o(o3[3]), .id_ex_flush_o(o3[2]), .ex_mem_stall_o(o3[1]),
        .pc_redirect_o(o3[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(sc3), .flush_cnt_o(fc3)
`endif
    );

    function automatic in_t inp(input logic [4:0] rs1, rs2, input logic u1, u2,
                                input logic [4:0] rd, input logic mr, bv, bt, bp, busy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
        v.mr = mr; v.bv = bv; v.bt = bt; v.bp = bp; v.busy = busy;
        return v;
    endfunction

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, x);
        end
    endfunction

    task automatic apply(input in_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_mem_read = v.mr;
        br_valid = v.bv; br_taken = v.bt; br_pred = v.bp; dmem_busy = v.busy;
    endtask

    task automatic step(input string n, input in_t v, input logic r,
                        input logic [6:0] e2, input logic [6:0] e3);
        sb_t e;
        @(posedge clk);
        #1;
        apply(v);
        reset = r;
        q.push_back('{e2, e3, r});
        if (r) begin
            m_s2 = 0; m_f2 = 0; m_s3 = 0; m_f3 = 0;
        end
        @(negedge clk);
        e = q.pop_front();
`ifdef HAZARD_PERF_CNT_EN
        chk({n, "/stall_cnt2"}, sc2, m_s2);
        chk({n, "/flush_cnt2"}, fc2, m_f2);
        chk({n, "/stall_cnt3"}, sc3, m_s3);
        chk({n, "/flush_cnt3"}, fc3, m_f3);
`endif
        chk({n, "/fc2"}, 32'(o2), 32'(e.e2));
        chk({n, "/fc3"}, 32'(o3), 32'(e.e3));
        if (!e.r) begin
            m_s2 += 32'(e.e2[6]); m_f2 += 32'(e.e2[0]);
            m_s3 += 32'(e.e3[6]); m_f3 += 32'(e.e3[0]);
        end
    endtask

    initial begin
        in_t idle, mis, mis_busy, busy, luin;
        idle     = inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mis      = inp(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        mis_busy = inp(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        busy     = inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        luin     = inp(0, 5, 0, 1, 5, 1, 0, 0, 0, 0);
        tbl[0]  = '{idle, Z, Z};
        tbl[1]  = '{luin, LU, LU};
        tbl[2]  = '{inp(7, 0, 1, 0, 7, 1, 0, 0, 0, 0), LU, LU};
        tbl[3]  = '{inp(0, 0, 1, 0, 0, 1, 0, 0, 0, 0), Z, Z};
        tbl[4]  = '{inp(5, 0, 0, 0, 5, 1, 0, 0, 0, 0), Z, Z};
        tbl[5]  = '{inp(5, 0, 1, 0, 5, 0, 0, 0, 0, 0), Z, Z};
        tbl[6]  = '{inp(0, 0, 0, 0, 0, 0, 1, 1, 1, 0), Z, Z};
        tbl[7]  = '{inp(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), Z, Z};
        tbl[8]  = '{inp(0, 5, 0, 1, 5, 1, 0, 0, 0, 1), FRZ, FRZ};
        tbl[9]  = '{idle, Z, Z};
        tbl[10] = '{busy, FRZ, FRZ};
        tbl[11] = '{luin, LU, LU};
        tbl[12] = '{idle, Z, Z};

        apply(idle);
        @(negedge clk);
        chk("reset_hold/fc2", 32'(o2), 0);
        chk("reset_hold/fc3", 32'(o3), 0);
        step("release", idle, 0, Z, Z);
        for (int i = 0; i < 13; i++) step($sformatf("vec%0d", i), tbl[i].i, 0, tbl[i].e2, tbl[i].e3);

        // mispredict, load-use ignored while flushing
        step("mis_c1", mis, 0, MIS, MIS);
        step("mis_c2", luin, 0, FL, FL);
        step("mis_c3", luin, 0, LU, FL);
        step("mis_c4", idle, 0, Z, Z);

        // mispredict held pending across a 3-cycle freeze
        step("mfz_c1", mis_busy, 0, FRZ, FRZ);
        step("mfz_c2", mis_busy, 0, FRZ, FRZ);
        step("mfz_c3", mis_busy, 0, FRZ, FRZ);
        step("mfz_c4", idle, 0, MIS, MIS);
        step("mfz_c5", idle, 0, FL, FL);
        step("mfz_c6", idle, 0, Z, FL);
        step("mfz_c7", idle, 0, Z, Z);

        // freeze in the middle of a flush resumes the remaining flush cycles
        step("ffz_c1", mis, 0, MIS, MIS);
        step("ffz_c2", busy, 0, FRZ, FRZ);
        step("ffz_c3", busy, 0, FRZ, FRZ);
        step("ffz_c4", idle, 0, FL, FL);
        step("ffz_c5", idle, 0, Z, FL);
        step("ffz_c6", idle, 0, Z, Z);

        // async reset in the middle of a flush, with busy and load-use driven
        step("rst_c1", mis, 0, MIS, MIS);
        step("rst_c2", inp(0, 5, 0, 1, 5, 1, 0, 0, 0, 1), 1, Z, Z);
        step("rst_c3", mis, 1, Z, Z);
        step("rst_c4", idle, 0, Z, Z);
        step("rst_c5", luin, 0, LU, LU);
        step("rst_c6", idle, 0, Z, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
